// File: rtl/vx_dispatch_arbiter.sv
// -----------------------------------------------------------------------------
// vx_dispatch_arbiter
//
// N-to-1 dispatch arbiter with a small elastic FIFO per input channel. The
// per-slice issue streams are buffered, then merged round-robin into a single
// registered valid/ready stream towards the shared execution-unit dispatch
// port. out_sel reports which channel sourced each output beat.
//
// Parameters:
//   NUM_REQS  number of input channels (1..16)
//   DATAW     payload width per channel
//   DEPTH     per-channel FIFO depth (power of two, >= 2)
//   SELW      derived channel index width, max(1, $clog2(NUM_REQS))
//
// Ports:
//   clk                clock, all state updates on the rising edge
//   reset              synchronous active-high reset
//   in_valid[N]        per-channel request valid
//   in_data[N*DATAW]   per-channel payload, channel i at [i*DATAW +: DATAW]
//   in_ready[N]        per-channel accept, driven from registered FIFO count
//   out_valid          output payload valid
//   out_data[DATAW]    output payload
//   out_sel[SELW]      channel index that sourced out_data
//   out_ready          downstream accept
//   perf_stall_cycles  cycles with out_valid && !out_ready   (perf build only)
//   perf_full_cycles   cycles with any in_valid && !in_ready (perf build only)
//
// Build option:
//   VX_DISPATCH_ARB_PERF_EN  when defined, adds the two 32-bit wrapping
//                            performance counters and their ports.
// -----------------------------------------------------------------------------
module vx_dispatch_arbiter #(
  parameter int NUM_REQS = 4,
  parameter int DATAW    = 64,
  parameter int DEPTH    = 2,
  localparam int SELW    = (NUM_REQS > 1) ? $clog2(NUM_REQS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [NUM_REQS-1:0]       in_valid,
  input  logic [NUM_REQS*DATAW-1:0] in_data,
  output logic [NUM_REQS-1:0]       in_ready,
  output logic                      out_valid,
  output logic [DATAW-1:0]          out_data,
  output logic [SELW-1:0]           out_sel,
  input  logic                      out_ready
`ifdef VX_DISPATCH_ARB_PERF_EN
  ,
  output logic [31:0]               perf_stall_cycles,
  output logic [31:0]               perf_full_cycles
`endif
);

  localparam int PTRW = $clog2(DEPTH);
  localparam int CNTW = PTRW + 1;

  logic [NUM_REQS-1:0] push;
  logic [NUM_REQS-1:0] pop;
  logic [NUM_REQS-1:0] nonempty;
  logic [DATAW-1:0]    head [NUM_REQS];

  logic            load;
  logic            found;
  logic            grant;
  logic [SELW-1:0] winner;
  logic [SELW-1:0] rr_ptr;
  logic [SELW-1:0] rr_next;

  // The output register may take a new beat when empty or being drained.
  assign load  = !out_valid || out_ready;
  assign grant = found && load;

  // ---------------------------------------------------------------------------
  // Per-channel FIFOs
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < NUM_REQS; i++) begin : g_fifo
    logic [CNTW-1:0]  count;
    logic [PTRW-1:0]  rd_ptr;
    logic [PTRW-1:0]  wr_ptr;
    logic [DATAW-1:0] mem [DEPTH];

    // in_ready depends only on the registered count, so a full FIFO cannot
    // accept in the cycle it pops; it reopens on the next cycle.
    assign in_ready[i] = (count != CNTW'(DEPTH));
    assign nonempty[i] = (count != '0);
    assign push[i]     = in_valid[i] && in_ready[i];
    assign pop[i]      = grant && (winner == SELW'(i));
    assign head[i]     = mem[rd_ptr];

    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of process evaluation order.
    always_ff @(posedge clk) begin
      if (reset) begin
        count  <= '0;
        rd_ptr <= '0;
        wr_ptr <= '0;
      end else begin
        if (push[i]) wr_ptr <= wr_ptr + 1'b1;
        if (pop[i])  rd_ptr <= rd_ptr + 1'b1;
        case ({push[i], pop[i]})
          2'b10:   count <= count + 1'b1;
          2'b01:   count <= count - 1'b1;
          default: ;
        endcase
      end
    end

    // NOTE: the storage array carries no reset; validity is tracked entirely
    // by count, so clearing the payload RAM would only cost area and timing.
    always_ff @(posedge clk) begin
      if (push[i]) mem[wr_ptr] <= in_data[i*DATAW +: DATAW];
    end
  end

  // ---------------------------------------------------------------------------
  // Round-robin pick: first non-empty channel at or after rr_ptr, wrapping.
  // ---------------------------------------------------------------------------
  always_comb begin
    int idx;
    // NOTE: every variable written here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    idx    = 0;
    found  = 1'b0;
    winner = '0;
    for (int k = 0; k < NUM_REQS; k++) begin
      idx = int'(rr_ptr) + k;
      if (idx >= NUM_REQS) idx = idx - NUM_REQS;
      if (!found && nonempty[idx]) begin
        found  = 1'b1;
        winner = SELW'(idx);
      end
    end
  end

  assign rr_next = (winner == SELW'(NUM_REQS - 1)) ? '0 : winner + 1'b1;

  // ---------------------------------------------------------------------------
  // Output register and priority pointer
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sel   <= '0;
      rr_ptr    <= '0;
    end else if (load) begin
      // With nothing buffered the register empties; payload and index hold.
      out_valid <= grant;
      if (grant) begin
        out_data <= head[winner];
        out_sel  <= winner;
        rr_ptr   <= rr_next;
      end
    end
  end

`ifdef VX_DISPATCH_ARB_PERF_EN
  // ---------------------------------------------------------------------------
  // Performance counters, wrapping modulo 2^32
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_full_cycles  <= '0;
    end else begin
      if (out_valid && !out_ready)     perf_stall_cycles <= perf_stall_cycles + 32'd1;
      if (|(in_valid & ~in_ready))     perf_full_cycles  <= perf_full_cycles + 32'd1;
    end
  end
`endif

endmodule
